universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised N-bit universal shift register with an auto-burst sequencer. It extends the basic load/shift-right register with several modes: bidirectional shift, rotate, optional arithmetic shift, and a counted burst that performs a fixed number of shifts without per-cycle control. It is the shared serialiser/deserialiser primitive for the datapath blocks.

## Interface
- `N`, default 8: register width; legal range N ≥ 2.
- `CW`, derived localparam `$clog2(N+1)`: width of the burst count.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset. One clock domain; reset is asynchronous and active-high.
- `op`  in  3  operation code; encodings live in the package.
- `d`  in  N  parallel load data.
- `si_r`  in  1  serial input entering at bit N-1 on right shifts.
- `si_l`  in  1  serial input entering at bit 0 on left shifts.
- `start`  in  1  request a counted burst.
- `count`  in  CW  number of shifts in the burst; legal range 0..N.
- `q`  out  N  register contents.
- `so_r`  out  1  equals `q[0]`.
- `so_l`  out  1  equals `q[N-1]`.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- Op codes:
  - 0 HOLD.
  - 1 LOAD: q←d.
  - 2 SHR: q←{si_r, q[N-1:1]}.
  - 3 SHL: q←{q[N-2:0], si_l}.
  - 4 ROR: q←{q[0], q[N-1:1]}.
  - 5 ROL: q←{q[N-2:0], q[N-1]}.
  - 6 ASR: q←{q[N-1], q[N-1:1]}.
  - 7 reserved, behaves as HOLD.
- State machine with two states, IDLE and BURST.
- IDLE, start=0: `op` executes every edge.
- IDLE, start=1: start wins and `op` is not executed at that edge. The block latches `op` as `bop` and `count` as `rem`.
  - If count=0, or `bop` ∉ {SHR, SHL, ROR, ROL, ASR}: stay in IDLE, q unchanged, done=1 for the next cycle.
  - Otherwise go to BURST with busy=1.
- BURST: each edge applies `bop` to q, sampling `si_r`/`si_l` live, and decrements `rem`.
  - When the edge that applies the final shift occurs (rem=1), go to IDLE with busy=0 and done=1 for one cycle.
- In BURST, `op`, `d`, `start` and `count` are ignored.
- start=1 on the cycle done is high is accepted as a new burst. Back-to-back bursts are legal.
- Reset (any time, including mid-burst): q=0, busy=0, done=0, state IDLE, rem=0. An interrupted burst produces no done.

## Timing
- Reset values: q=0, so_r=0, so_l=0, busy=0, done=0.
- Immediate ops: result visible in q one edge after `op` is sampled.
- Burst with count=k>0:
  - start sampled at edge E0.
  - Shifts occur at edges E1..Ek.
  - busy is high from after E0 to after Ek.
  - done is high for exactly the cycle after Ek.
  - Latency from start to done is k+1 edges.
- Degenerate start (count=0 or non-shift op): done is high the cycle after E0 and busy never rises.
- so_r and so_l are combinational from q; no extra latency.

## Configuration
- `USR_ASR_EN` defined: op 6 performs the arithmetic right shift.
- `USR_ASR_EN` undefined:
  - op 6 behaves as HOLD.
  - A burst started with op 6 is treated as a non-shift op: immediate done, q unchanged.

## Structure
- Package `usr_pkg` holds:
  - op-code localparams `USR_OP_HOLD` through `USR_OP_ASR`.
  - FSM state encodings `USR_ST_IDLE` and `USR_ST_BURST`.
  - the function that tests whether an op is a shift op.
- One sub-module, `usr_shift_core`: purely combinational next-value logic from (op, q, d, si_r, si_l) to q_next. It is shared by immediate mode and burst mode.
- The top level holds the q register, the FSM, `rem`, `bop` and the done register.

## Test plan
- Assert reset mid-operation → q=0x00, busy=0, done=0 immediately (asynchronous).
- N=8: LOAD 0xA5, then SHR with si_r=1 → 0xD2, then SHL with si_l=0 → 0xA4.
- Rotate from q=0x81: ROR → 0xC0. Separately, ROL from q=0x81 → 0x03.
- ASR from q=0x80: with `USR_ASR_EN` → 0xC0; without it → 0x80.
- Burst: q=0xF0, op=SHR, si_r=0, count=4, start pulse, with op changed to LOAD during the burst:
  - busy high for 4 cycles.
  - q=0x0F when done pulses.
  - LOAD ignored.
- Edge bursts:
  - count=0 → done the next cycle, busy stays 0.
  - reset after 2 of 4 shifts → q=0x00, no done pulse.
  - back-to-back start on the done cycle → second burst runs.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared op codes, FSM states and op classification for universal_shift_register.
// Whether op 6 counts as a shift depends on USR_ASR_EN.
package usr_pkg;

  localparam logic [2:0] USR_OP_HOLD = 3'd0;
  localparam logic [2:0] USR_OP_LOAD = 3'd1;
  localparam logic [2:0] USR_OP_SHR  = 3'd2;
  localparam logic [2:0] USR_OP_SHL  = 3'd3;
  localparam logic [2:0] USR_OP_ROR  = 3'd4;
  localparam logic [2:0] USR_OP_ROL  = 3'd5;
  localparam logic [2:0] USR_OP_ASR  = 3'd6;

  typedef enum logic {
    USR_ST_IDLE  = 1'b0,
    USR_ST_BURST = 1'b1
  } usr_state_e;

  function automatic logic usr_is_shift(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      USR_OP_SHR, USR_OP_SHL, USR_OP_ROR, USR_OP_ROL: r = 1'b1;
`ifdef USR_ASR_EN
      USR_OP_ASR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value logic for the shift register, shared by immediate and burst modes.
// Op 6 is an arithmetic right shift only when USR_ASR_EN is defined; otherwise it holds.
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  input  logic         si_r_i,
  input  logic         si_l_i,
  output logic [N-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (op_i)
      USR_OP_LOAD: q_next_o = d_i;
      USR_OP_SHR:  q_next_o = {si_r_i, q_i[N-1:1]};
      USR_OP_SHL:  q_next_o = {q_i[N-2:0], si_l_i};
      USR_OP_ROR:  q_next_o = {q_i[0], q_i[N-1:1]};
      USR_OP_ROL:  q_next_o = {q_i[N-2:0], q_i[N-1]};
`ifdef USR_ASR_EN
      USR_OP_ASR:  q_next_o = {q_i[N-1], q_i[N-1:1]};
`endif
      default:     q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with a counted auto-burst sequencer (IDLE/BURST FSM).
// Optional arithmetic right shift (op 6) is enabled by defining USR_ASR_EN.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    op,
  input  logic [N-1:0]  d,
  input  logic          si_r,
  input  logic          si_l,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);

  usr_state_e    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [2:0]    bop_q, bop_d;
  logic          done_q, done_d;
  logic [2:0]    core_op;
  logic [N-1:0]  core_q_next;

  usr_shift_core #(.N(N)) u_core (
    .op_i     (core_op),
    .q_i      (q_q),
    .d_i      (d),
    .si_r_i   (si_r),
    .si_l_i   (si_l),
    .q_next_o (core_q_next)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    bop_d   = bop_q;
    done_d  = 1'b0;
    core_op = op;
    case (state_q)
      USR_ST_IDLE: begin
        if (start) begin
          // A start edge never executes op; degenerate bursts just report done.
          bop_d = op;
          rem_d = count;
          if (count == '0 || !usr_is_shift(op)) begin
            done_d = 1'b1;
          end else begin
            state_d = USR_ST_BURST;
          end
        end else begin
          q_d = core_q_next;
        end
      end
      USR_ST_BURST: begin
        core_op = bop_q;
        q_d     = core_q_next;
        rem_d   = rem_q - CW'(1);
        if (rem_q == CW'(1)) begin
          state_d = USR_ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = USR_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= USR_ST_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      bop_q   <= USR_OP_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      bop_q   <= bop_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[N-1];
  assign busy = (state_q == USR_ST_BURST);
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N=8): vector table for immediate ops,
// hand-written sequences for bursts and asynchronous reset; expectations flow through a queue.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

`ifdef USR_ASR_EN
  localparam logic [7:0] ASR_EXP = 8'hC0;
`else
  localparam logic [7:0] ASR_EXP = 8'h80;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op;
  logic [N-1:0]  d;
  logic          si_r, si_l, start;
  logic [CW-1:0] count;
  logic [N-1:0]  q;
  logic          so_r, so_l, busy, done;

  universal_shift_register #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .d     (d),
    .si_r  (si_r),
    .si_l  (si_l),
    .start (start),
    .count (count),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       so_r;
    logic       so_l;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic       si_r;
    logic       si_l;
    logic [7:0] exp_q;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[15];
  int   tests  = 0;
  int   failed = 0;

  function automatic obs_t mk(input logic [7:0] eq, input logic eb, input logic ed);
    obs_t o;
    o.q    = eq;
    o.so_r = eq[0];
    o.so_l = eq[7];
    o.busy = eb;
    o.done = ed;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got q=%h so_r=%b so_l=%b busy=%b done=%b, want q=%h so_r=%b so_l=%b busy=%b done=%b",
               name, got.q, got.so_r, got.so_l, got.busy, got.done,
               exp.q, exp.so_r, exp.so_l, exp.busy, exp.done);
    end
  endtask

  task automatic step(input string name);
    obs_t exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      check(name, {q, so_r, so_l, busy, done}, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] dd, input logic sr, input logic sl,
                       input logic st, input logic [CW-1:0] c);
    op = o; d = dd; si_r = sr; si_l = sl; start = st; count = c;
  endtask

  initial begin
    vecs[0]  = '{USR_OP_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{USR_OP_SHR,  8'h00, 1'b1, 1'b0, 8'hD2};
    vecs[2]  = '{USR_OP_SHL,  8'h00, 1'b0, 1'b0, 8'hA4};
    vecs[3]  = '{USR_OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[4]  = '{USR_OP_ROR,  8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[5]  = '{USR_OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[6]  = '{USR_OP_ROL,  8'h00, 1'b0, 1'b0, 8'h03};
    vecs[7]  = '{USR_OP_LOAD, 8'h80, 1'b0, 1'b0, 8'h80};
    vecs[8]  = '{USR_OP_ASR,  8'h00, 1'b0, 1'b0, ASR_EXP};
    vecs[9]  = '{USR_OP_HOLD, 8'hFF, 1'b1, 1'b1, ASR_EXP};
    vecs[10] = '{3'd7,        8'hFF, 1'b1, 1'b1, ASR_EXP};
    vecs[11] = '{USR_OP_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[12] = '{USR_OP_SHL,  8'h00, 1'b0, 1'b1, 8'h79};
    vecs[13] = '{USR_OP_SHR,  8'h00, 1'b0, 1'b0, 8'h3C};
    vecs[14] = '{USR_OP_ROL,  8'h00, 1'b0, 1'b0, 8'h78};

    reset = 1'b1;
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    #2;
    check("reset_state", {q, so_r, so_l, busy, done}, mk(8'h00, 1'b0, 1'b0));
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].d, vecs[i].si_r, vecs[i].si_l, 1'b0, '0);
      sb.push_back(mk(vecs[i].exp_q, 1'b0, 1'b0));
      step($sformatf("vec%0d", i));
    end

    // Burst SHR x4 with op switched to LOAD mid-burst.
    drive(USR_OP_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'hF0, 1'b0, 1'b0)); step("burst_pre");
    drive(USR_OP_SHR, 8'h00, 1'b0, 1'b0, 1'b1, CW'(4));
    sb.push_back(mk(8'hF0, 1'b1, 1'b0)); step("burst_e0");
    drive(USR_OP_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, CW'(7));
    sb.push_back(mk(8'h78, 1'b1, 1'b0)); step("burst_e1");
    sb.push_back(mk(8'h3C, 1'b1, 1'b0)); step("burst_e2");
    sb.push_back(mk(8'h1E, 1'b1, 1'b0)); step("burst_e3");
    sb.push_back(mk(8'h0F, 1'b0, 1'b1)); step("burst_e4_done");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h0F, 1'b0, 1'b0)); step("burst_after");

    // Degenerate starts: count=0, then a non-shift op.
    drive(USR_OP_SHR, 8'h00, 1'b1, 1'b0, 1'b1, '0);
    sb.push_back(mk(8'h0F, 1'b0, 1'b1)); step("cnt0_done");
    drive(USR_OP_LOAD, 8'hAA, 1'b0, 1'b0, 1'b1, CW'(3));
    sb.push_back(mk(8'h0F, 1'b0, 1'b1)); step("nonshift_done");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h0F, 1'b0, 1'b0)); step("degen_after");

    // Back-to-back: SHL x2 then ROL x1 started on the done cycle.
    drive(USR_OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h81, 1'b0, 1'b0)); step("b2b_pre");
    drive(USR_OP_SHL, 8'h00, 1'b0, 1'b0, 1'b1, CW'(2));
    sb.push_back(mk(8'h81, 1'b1, 1'b0)); step("b2b_e0");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    sb.push_back(mk(8'h03, 1'b1, 1'b0)); step("b2b_e1");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h06, 1'b0, 1'b1)); step("b2b_done1");
    drive(USR_OP_ROL, 8'h00, 1'b0, 1'b0, 1'b1, CW'(1));
    sb.push_back(mk(8'h06, 1'b1, 1'b0)); step("b2b_start2");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h0C, 1'b0, 1'b1)); step("b2b_done2");
    sb.push_back(mk(8'h0C, 1'b0, 1'b0)); step("b2b_after");

    // Asynchronous reset after 2 of 4 shifts: no done may follow.
    drive(USR_OP_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'hF0, 1'b0, 1'b0)); step("rst_pre");
    drive(USR_OP_SHR, 8'h00, 1'b0, 1'b0, 1'b1, CW'(4));
    sb.push_back(mk(8'hF0, 1'b1, 1'b0)); step("rst_e0");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h78, 1'b1, 1'b0)); step("rst_e1");
    sb.push_back(mk(8'h3C, 1'b1, 1'b0)); step("rst_e2");
    #2 reset = 1'b1;
    #1 check("rst_async", {q, so_r, so_l, busy, done}, mk(8'h00, 1'b0, 1'b0));
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(8'h00, 1'b0, 1'b0));
      step($sformatf("rst_nodone%0d", i));
    end

`ifdef USR_ASR_EN
    drive(USR_OP_LOAD, 8'h80, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h80, 1'b0, 1'b0)); step("asr_pre");
    drive(USR_OP_ASR, 8'h00, 1'b0, 1'b0, 1'b1, CW'(2));
    sb.push_back(mk(8'h80, 1'b1, 1'b0)); step("asr_e0");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'hC0, 1'b1, 1'b0)); step("asr_e1");
    sb.push_back(mk(8'hE0, 1'b0, 1'b1)); step("asr_done");
`else
    drive(USR_OP_LOAD, 8'h80, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h80, 1'b0, 1'b0)); step("asr_pre");
    drive(USR_OP_ASR, 8'h00, 1'b0, 1'b0, 1'b1, CW'(2));
    sb.push_back(mk(8'h80, 1'b0, 1'b1)); step("asr_degen");
    drive(USR_OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    sb.push_back(mk(8'h80, 1'b0, 1'b0)); step("asr_after");
`endif

    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
